alu_resp: RTL and testbench

Handshaked, multi-cycle responder for ALU operations. It accepts one command at a time (operands plus 3-bit op), computes the result through the team's combinational ALU, and returns the result with zero, overflow and illegal-op status over a valid/ready response channel. This is the request/response end that stimulus generators and the future multi-cycle datapath controller talk to, replacing direct combinational hookup to the ALU.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/yAlu.sv | 38 +++
 rtl/alu_resp.sv | 113 +++++++++++
 tb/tb_alu_resp.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: op-code constants, responder state encoding and a
// helper that tells legal op codes from illegal ones.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/yAlu.sv
// yAlu: combinational 32-bit ALU.
//   a, b : operands
//   op   : operation (op[2] selects b inversion / subtract, op[1:0] selects
//          AND, OR, SUM, SLT)
//   z    : result
//   ex   : result-is-zero indication
// Codes outside the legal set produce an unspecified result; callers mask.
module yAlu (
    output logic [31:0] z,
    output logic        ex,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op
);

    logic [31:0] bb;
    logic [31:0] sum;
    logic        lt;

    assign bb  = op[2] ? ~b : b;
    assign sum = a + bb + {31'd0, op[2]};
    // Signed less-than: sign of a-b, corrected when the subtraction overflows.
    assign lt  = sum[31] ^ ((a[31] != b[31]) && (sum[31] != a[31]));

    always_comb begin
        z = '0;
        case (op[1:0])
            2'b00: z = a & b;
            2'b01: z = a | b;
            2'b10: z = sum;
            2'b11: z = {31'd0, lt};
            default: z = '0;
        endcase
    end

    assign ex = (z == '0);

endmodule

// File: rtl/alu_resp.sv
// alu_resp: handshaked multi-cycle responder around yAlu.
//   clk, rst           : clock, asynchronous active-high reset
//   req_valid/ready    : command handshake; req_a, req_b, req_op command fields
//   rsp_valid/ready    : response handshake
//   rsp_z              : result (0 for illegal ops)
//   rsp_zero/ovf/err   : zero, signed overflow (add/sub), illegal op flags
//   done_cnt           : completed responses, wrapping
// One command in flight: IDLE accepts, EXEC waits LATENCY cycles, RESP holds
// the registered result until the consumer takes it.
module alu_resp
    import alu_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [2:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_z,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_err,
    output logic [CNT_W-1:0] done_cnt
);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q;
    logic [31:0] a_q, b_q;
    logic [2:0]  op_q;

    logic [31:0] alu_z;
    logic        alu_ex_unused;
    logic        res_legal;
    logic [31:0] res_z;
    logic        res_ovf;

    yAlu u_alu (
        .z  (alu_z),
        .ex (alu_ex_unused),
        .a  (a_q),
        .b  (b_q),
        .op (op_q)
    );

    assign res_legal = op_legal(op_q);
    assign res_z     = res_legal ? alu_z : '0;
    assign res_ovf   = ((op_q == OP_ADD) && (a_q[31] == b_q[31]) && (alu_z[31] != a_q[31])) ||
                       ((op_q == OP_SUB) && (a_q[31] != b_q[31]) && (alu_z[31] != a_q[31]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid)     state_d = S_EXEC;
            S_EXEC:  if (cnt_q == 2'd0) state_d = S_RESP;
            S_RESP:  if (rsp_ready)     state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = (state_q == S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            rsp_z    <= '0;
            rsp_zero <= 1'b0;
            rsp_ovf  <= 1'b0;
            rsp_err  <= 1'b0;
            done_cnt <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        a_q   <= req_a;
                        b_q   <= req_b;
                        op_q  <= req_op;
                        cnt_q <= 2'(LATENCY - 1);
                    end
                end
                S_EXEC: begin
                    if (cnt_q == 2'd0) begin
                        rsp_z    <= res_z;
                        rsp_zero <= (res_z == '0);
                        rsp_ovf  <= res_ovf;
                        rsp_err  <= !res_legal;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) done_cnt <= done_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_resp.sv
// Self-checking bench for alu_resp: one instance at LATENCY=1 (index 0) and
// one at LATENCY=3 (index 1), checked against a plain-arithmetic ALU model.
module tb_alu_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_a     [2];
    logic [31:0] req_b     [2];
    logic [2:0]  req_op    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_z     [2];
    logic        rsp_zero  [2];
    logic        rsp_ovf   [2];
    logic        rsp_err   [2];
    logic [15:0] done_cnt  [2];

    int unsigned lat_of [2] = '{1, 3};
    logic [15:0] exp_cnt [2] = '{16'd0, 16'd0};
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    alu_resp #(.LATENCY(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .req_op(req_op[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_z(rsp_z[0]), .rsp_zero(rsp_zero[0]), .rsp_ovf(rsp_ovf[0]),
        .rsp_err(rsp_err[0]), .done_cnt(done_cnt[0])
    );

    alu_resp #(.LATENCY(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .req_op(req_op[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_z(rsp_z[1]), .rsp_zero(rsp_zero[1]), .rsp_ovf(rsp_ovf[1]),
        .rsp_err(rsp_err[1]), .done_cnt(done_cnt[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: results from the op table using signed 64-bit arithmetic.
    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op, output logic [31:0] z,
                                    output logic ovf, output logic err);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint r  = 0;
        z = '0; ovf = 1'b0; err = 1'b0;
        case (op)
            3'b000: z = a & b;
            3'b001: z = a | b;
            3'b010: begin r = sa + sb; z = r[31:0]; ovf = (r != longint'($signed(r[31:0]))); end
            3'b110: begin r = sa - sb; z = r[31:0]; ovf = (r != longint'($signed(r[31:0]))); end
            3'b111: z = (sa < sb) ? 32'd1 : 32'd0;
            default: begin z = '0; err = 1'b1; end
        endcase
    endfunction

    task automatic check_reset_vals(input int d);
        check("rst_req_ready", req_ready[d], 0);
        check("rst_rsp_valid", rsp_valid[d], 0);
        check("rst_rsp_z", rsp_z[d], 0);
        check("rst_flags", {rsp_zero[d], rsp_ovf[d], rsp_err[d]}, 0);
        check("rst_done_cnt", done_cnt[d], 0);
    endtask

    // Called 1 time unit after a rising edge with the instance idle.
    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input int hold);
        logic [31:0] ez;
        logic        eovf, eerr;
        int          n;
        ref_alu(a, b, op, ez, eovf, eerr);
        check("idle_req_ready", req_ready[d], 1);
        req_valid[d] = 1'b1; req_a[d] = a; req_b[d] = b; req_op[d] = op;
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_a[d] = $urandom; req_b[d] = $urandom; req_op[d] = 3'($urandom);
        check("exec_req_ready", req_ready[d], 0);
        n = 0;
        while (!rsp_valid[d] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("latency", n, lat_of[d]);
        check("rsp_z", rsp_z[d], ez);
        check("rsp_zero", rsp_zero[d], ez == 0);
        check("rsp_ovf", rsp_ovf[d], eovf);
        check("rsp_err", rsp_err[d], eerr);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid[d], 1);
            check("hold_z", rsp_z[d], ez);
            check("hold_flags", {rsp_zero[d], rsp_ovf[d], rsp_err[d]}, {ez == 0, eovf, eerr});
            check("hold_req_ready", req_ready[d], 0);
            check("hold_done_cnt", done_cnt[d], exp_cnt[d]);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        exp_cnt[d] = exp_cnt[d] + 16'd1;
        check("post_valid", rsp_valid[d], 0);
        check("post_done_cnt", done_cnt[d], exp_cnt[d]);
        check("post_z_held", rsp_z[d], ez);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          acc_cyc [2];
        logic [31:0] got_z   [2];
        logic [31:0] ez;
        logic        eovf, eerr;
        int          na, nr, cyc;
        logic        acc_now, rsp_now;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_a[d] = '0; req_b[d] = '0; req_op[d] = '0;
            rsp_ready[d] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals(0);
        check_reset_vals(1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases on LATENCY=1
        txn(0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 0);
        txn(0, 32'h0000_0005, 32'h0000_0005, 3'b110, 0);
        txn(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 0);
        txn(0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b100, 0);
        txn(0, 32'h8000_0000, 32'h0000_0001, 3'b110, 5);

        // Back-to-back AND then OR on LATENCY=3 with both valid and ready held
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1; req_a[1] = 32'hF0F0_F0F0; req_b[1] = 32'hFF00_FF00; req_op[1] = 3'b000;
        na = 0; nr = 0; cyc = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0; got_z[0] = '0; got_z[1] = '0;
        while ((na < 2 || nr < 2) && cyc < 60) begin
            acc_now = req_valid[1] && req_ready[1];
            rsp_now = rsp_valid[1] && rsp_ready[1];
            if (rsp_now && nr < 2) begin got_z[nr] = rsp_z[1]; nr++; end
            @(posedge clk); #1; cyc++;
            if (acc_now && na < 2) begin
                acc_cyc[na] = cyc; na++;
                req_op[1] = 3'b001;
                if (na == 2) req_valid[1] = 1'b0;
            end
        end
        rsp_ready[1] = 1'b0;
        exp_cnt[1] = exp_cnt[1] + 16'(nr);
        check("b2b_accepts", na, 2);
        check("b2b_responses", nr, 2);
        check("b2b_interval", acc_cyc[1] - acc_cyc[0], 5);
        ref_alu(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, ez, eovf, eerr);
        check("b2b_and", got_z[0], ez);
        ref_alu(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, ez, eovf, eerr);
        check("b2b_or", got_z[1], ez);
        check("b2b_done_cnt", done_cnt[1], exp_cnt[1]);

        // Reset in the middle of EXEC on LATENCY=3
        req_valid[1] = 1'b1; req_a[1] = 32'h1234_5678; req_b[1] = 32'h1111_1111; req_op[1] = 3'b010;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_vals(0);
        check_reset_vals(1);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt[0] = '0; exp_cnt[1] = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_rsp", rsp_valid[1], 0);
        end
        check("post_rst_done_cnt", done_cnt[1], 0);
        txn(1, 32'h1234_5678, 32'h1111_1111, 3'b010, 1);

        // Randomized traffic on both instances
        for (int i = 0; i < 25; i++) begin
            for (int d = 0; d < 2; d++) begin
                txn(d, pick_operand(), pick_operand(), 3'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
